// File: rtl/apb_slave_regfile_if.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile_if
// APB4 bus bundle between a requester (master modport) and the register
// bank completer (slave modport).
//   psel, penable, paddr[11:0], pwrite, pprot[2:0], pstrb[3:0], pwdata[31:0]
//       : requester -> completer
//   prdata[31:0], pready, pslverr
//       : completer -> requester
// ---------------------------------------------------------------------------
interface apb_slave_regfile_if;
    logic        psel;
    logic        penable;
    logic [11:0] paddr;
    logic        pwrite;
    logic [2:0]  pprot;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pprot, pstrb, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pprot, pstrb, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
// APB4 completer register bank: ID (RO), CTRL (RW, privileged writes),
// STATUS (W1C sticky overflow), COUNT (RO free-running counter) and
// NUM_SCRATCH byte-strobed scratch registers, with programmable wait states
// and PSLVERR reporting.
// Ports:
//   pclk    : APB clock
//   presetn : asynchronous active-low reset
//   apb     : APB4 slave modport (psel/penable/paddr/pwrite/pprot/pstrb/
//             pwdata in, prdata/pready/pslverr out)
//   irq     : level interrupt = STATUS.ovf & CTRL.irq_en
// ---------------------------------------------------------------------------
module apb_slave_regfile #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
    parameter int          NUM_SCRATCH = 4
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_slave_regfile_if.slave  apb,
    output logic                irq
);

    localparam int            WW        = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WAIT_INIT = WW'(WAIT_CYCLES);

    logic [WW-1:0] r_wait;
    logic [7:0]    r_ctrl;
    logic          r_ovf;
    logic [31:0]   r_count;
    logic [31:0]   r_scratch [NUM_SCRATCH];

    logic [9:0]    w_word;
    logic          w_is_id;
    logic          w_is_ctrl;
    logic          w_is_status;
    logic          w_is_count;
    logic          w_is_scr;
    logic [31:0]   w_scr_rd;
    logic [31:0]   w_rdata;
    logic          w_err;
    logic          w_ready;
    logic          w_commit;
    logic          w_wrap;
    logic [1:0]    w_unused_prot;

    assign w_unused_prot = apb.pprot[2:1];
    assign w_word        = apb.paddr[11:2];

    // Wait counter: loaded in setup, counted down in access; cleared when
    // idle so that an access without a setup cycle completes at once.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wait <= '0;
        end else if (!apb.psel) begin
            r_wait <= '0;
        end else if (!apb.penable) begin
            r_wait <= WAIT_INIT;
        end else if (r_wait != '0) begin
            r_wait <= r_wait - WW'(1);
        end else begin
            r_wait <= r_wait;
        end
    end

    // Address decode, read mux and error classification.
    always_comb begin
        w_is_id     = (w_word == 10'd0);
        w_is_ctrl   = (w_word == 10'd1);
        w_is_status = (w_word == 10'd2);
        w_is_count  = (w_word == 10'd3);
        w_is_scr    = 1'b0;
        w_scr_rd    = 32'h0000_0000;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (w_word == 10'(4 + i)) begin
                w_is_scr = 1'b1;
                w_scr_rd = r_scratch[i];
            end else begin
                w_is_scr = w_is_scr;
            end
        end
        case (w_word)
            10'd0:   w_rdata = ID_VALUE;
            10'd1:   w_rdata = {24'h00_0000, r_ctrl};
            10'd2:   w_rdata = {31'h0000_0000, r_ovf};
            10'd3:   w_rdata = r_count;
            default: w_rdata = w_scr_rd;  // zero when not a scratch word
        endcase
        w_err = (apb.paddr[1:0] != 2'b00)
              | !(w_is_id | w_is_ctrl | w_is_status | w_is_count | w_is_scr)
              | (apb.pwrite & (w_is_id | w_is_count))
              | (apb.pwrite & w_is_ctrl & !apb.pprot[0]);
    end

    // Reset forces pready low immediately, even mid-transfer.
    assign w_ready     = presetn & apb.psel & apb.penable & (r_wait == '0);
    assign w_commit    = w_ready & apb.pwrite & !w_err;
    assign w_wrap      = r_ctrl[0] & (r_count == 32'hFFFF_FFFF);

    assign apb.pready  = w_ready;
    assign apb.pslverr = w_ready & w_err;
    assign apb.prdata  = (w_ready & !apb.pwrite & !w_err) ? w_rdata : 32'h0000_0000;
    assign irq         = r_ovf & r_ctrl[1];

    // CTRL: low byte stored, pstrb ignored.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ctrl <= 8'h00;
        end else if (w_commit && w_is_ctrl) begin
            r_ctrl <= apb.pwdata[7:0];
        end else begin
            r_ctrl <= r_ctrl;
        end
    end

    // COUNT: free-running while cnt_en, wraps to zero.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_count <= 32'h0000_0000;
        end else if (r_ctrl[0]) begin
            r_count <= r_count + 32'd1;
        end else begin
            r_count <= r_count;
        end
    end

    // STATUS.ovf: sticky; a wrap in the same cycle as a W1C clear wins.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end else if (w_commit && w_is_status && apb.pwdata[0]) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    // SCRATCH: byte-lane writes under pstrb.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                r_scratch[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_commit && (w_word == 10'(4 + i)) && apb.pstrb[b]) begin
                        r_scratch[i][8*b +: 8] <= apb.pwdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB4 completer register bank sitting directly downstream of the APB clock-domain bridge; it is the target on the bridge's b-side master port.
- Provides the following:
  - ID register
  - control register
  - sticky status with interrupt
  - free-running counter
  - byte-strobed scratch registers
- Supports programmable wait states and PSLVERR reporting, so the bridge's ready/error return path is exercised end to end.

Parameters:
WAIT_CYCLES, 1, access-phase wait states inserted before PREADY (0 = zero-wait)
ID_VALUE, 32'hA5B0_0001, read-only value of ID register
NUM_SCRATCH, 4, number of scratch registers at 0x010 upward (1..4)

Ports:
pclk  input  1  APB clock
presetn  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
paddr  input  12  byte address
pwrite  input  1  1 = write, 0 = read
pprot  input  3  protection; bit0 = privileged
pstrb  input  4  write byte strobes
pwdata  input  32  write data
prdata  output  32  read data
pready  output  1  transfer complete
pslverr  output  1  transfer error, valid with pready
irq  output  1  interrupt, level

Behaviour:
- Clock and reset: single clock pclk; reset presetn is asynchronous assert, active-low. All state clears on reset, including in mid-transfer:
  - CTRL = 0, STATUS = 0, COUNT = 0, SCRATCH = 0
  - wait counter = 0
  - irq = 0
  - pready, pslverr and prdata read 0 while psel = 0
- Register map (word offsets; any other address is unmapped):
  - 0x000 ID: RO, returns ID_VALUE.
  - 0x004 CTRL: RW.
    - bits[7:0] are stored; bits[31:8] read 0.
    - bit0 = cnt_en, bit1 = irq_en.
    - Writes require pprot[0] = 1.
  - 0x008 STATUS: W1C.
    - bit0 = ovf (sticky); other bits read 0.
  - 0x00C COUNT: RO.
    - Increments by 1 each cycle while cnt_en = 1.
    - 32'hFFFF_FFFF wraps to 0 and sets ovf in the same cycle.
  - 0x010 + 4*i SCRATCH[i], i < NUM_SCRATCH: RW with byte strobes.
- Wait-state timing:
  - Setup cycle (psel & !penable) loads the wait counter with WAIT_CYCLES.
  - Each access cycle (psel & penable) with counter != 0 decrements it; pready = 0.
  - pready = psel & penable & (counter == 0), combinational. A transfer therefore completes in exactly WAIT_CYCLES+1 access cycles.
- Error (pslverr = 1 in the pready cycle) when any of the following holds:
  - paddr[1:0] != 0
  - address unmapped
  - write to ID or COUNT
  - write to CTRL with pprot[0] = 0
- Erroring transfers change no state and return prdata = 0. Reads never error on pprot.
- prdata = selected register, driven only when pready = 1 and the access is a non-erroring read; 0 otherwise.
- Write commit occurs on the pclk edge ending the pready cycle:
  - CTRL takes pwdata[7:0] and ignores pstrb.
  - SCRATCH updates only the bytes whose pstrb bit is set; pstrb = 0 is a legal no-op with OKAY response.
  - STATUS clears bits where pwdata = 1.
- Simultaneous events:
  - COUNT wrap and a W1C clear of ovf in the same cycle: the set wins, so ovf stays 1.
  - A CTRL write changing cnt_en takes effect from the next cycle. The COUNT value read in the same cycle as the write is the pre-edge value.
- irq = STATUS.ovf & CTRL.irq_en, registered-state only, no extra latency beyond the state flops.
- Protocol tolerance: psel dropping mid-wait aborts the transfer with no state change; the counter reloads on the next setup cycle. penable without a prior setup cycle is treated as an access with counter 0.

Test Plan:
1. Reset, then read 0x000 with WAIT_CYCLES = 1 -> pready low 1 access cycle, then high with prdata = 32'hA5B0_0001, pslverr = 0.
2. Privileged write 0x004 = 32'h0000_0103, read back -> 32'h0000_0003. Unprivileged (pprot = 0) write 32'h0 -> pslverr = 1; readback still 32'h3.
3. Write SCRATCH0 = 32'h1122_3344 (pstrb = 4'hF), then 32'hAABB_CCDD with pstrb = 4'b0101 -> readback 32'h11BB_33DD.
4. Force COUNT near wrap (cnt_en = 1, irq_en = 1, bench preloads 32'hFFFF_FFFE via hierarchical deposit) -> after 2 cycles COUNT = 0, STATUS = 1, irq = 1. Write STATUS = 1 -> irq = 0 next cycle. Also clear in the exact wrap cycle -> STATUS stays 1.
5. Error cases -> pslverr = 1, prdata = 0, no state change:
   - read 0x020 with NUM_SCRATCH = 4
   - read 0x006 (misaligned)
   - write 0x00C
6. Assert presetn during the wait state of a SCRATCH1 write -> pready = 0 immediately, SCRATCH1 = 0, CTRL = 0 afterward. A next transfer with WAIT_CYCLES = 0 completes in its first access cycle.
